matmul_tile_scheduler: RTL and testbench

Sequences the 8x8 systolic-array driver over matrices of up to 64x64 words. The block splits C = A x B into 8x8 output tiles and launches one driver pass per (output tile, K-slice). It accumulates partial products in a local 8x8 buffer and writes each finished tile back to memory over a write handshake. It sits between the command decoder (start/config) and the array driver plus memory write port.

---
 rtl/matmul_tile_scheduler.sv | 174 +++++++++++++++++
 tb/tb_matmul_tile_scheduler.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_tile_scheduler.sv
// rtl/matmul_tile_scheduler.sv - tiles C = A x B into 8x8 driver passes, accumulates and writes back C
module matmul_tile_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int DIM_WIDTH  = 7,
    parameter int TILE       = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic [ADDR_WIDTH-1:0]              base_A,
    input  logic [ADDR_WIDTH-1:0]              base_B,
    input  logic [ADDR_WIDTH-1:0]              base_C,
    input  logic [DIM_WIDTH-1:0]               dim_M,
    input  logic [DIM_WIDTH-1:0]               dim_K,
    input  logic [DIM_WIDTH-1:0]               dim_N,
    output logic                               busy,
    output logic                               done,
    output logic                               err,
    output logic                               sa_start,
    output logic [ADDR_WIDTH-1:0]              sa_base_A,
    output logic [ADDR_WIDTH-1:0]              sa_base_B,
    output logic [DIM_WIDTH-1:0]               sa_dim_col_A,
    output logic [DIM_WIDTH-1:0]               sa_dim_col_B,
    input  logic                               sa_done,
    input  logic [TILE*TILE*DATA_WIDTH-1:0]    sa_out,
    output logic                               write,
    output logic [ADDR_WIDTH-1:0]              write_addr,
    output logic [DATA_WIDTH-1:0]              writedata,
    input  logic                               write_ready
);
    localparam int NELEM = TILE * TILE;
    localparam int CW    = DIM_WIDTH - 3;

    typedef enum logic [2:0] {
        S_IDLE, S_ERR, S_LAUNCH, S_WAIT_SA, S_ACCUM, S_WRITE, S_DONE
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0]       base_a_q, base_b_q, base_c_q;
    logic [CW-1:0]               m_tiles_q;
    logic [DIM_WIDTH-1:0]        dim_k_q, dim_n_q;
    logic [2:0]                  ti, tj, tk;
    logic [5:0]                  idx;
    logic [NELEM*DATA_WIDTH-1:0] acc;

    logic last_tk, last_tj, last_ti, cfg_ok, last_idx;
    logic [ADDR_WIDTH-1:0] k_a, n_a, ti8, tj8, tk8, r_a, c_a;
    logic [ADDR_WIDTH-1:0] addr_a, addr_b, addr_c;

    function automatic logic dim_ok(input logic [DIM_WIDTH-1:0] d);
        return (d != '0) && (d[2:0] == 3'b000) && (d <= DIM_WIDTH'(64));
    endfunction

    assign cfg_ok   = dim_ok(dim_M) && dim_ok(dim_K) && dim_ok(dim_N);
    assign last_tk  = (CW'(tk) + CW'(1)) == dim_k_q[DIM_WIDTH-1:3];
    assign last_tj  = (CW'(tj) + CW'(1)) == dim_n_q[DIM_WIDTH-1:3];
    assign last_ti  = (CW'(ti) + CW'(1)) == m_tiles_q;
    assign last_idx = (idx == 6'd63);

    // All address math is truncated to ADDR_WIDTH, so bases wrap around the space
    assign k_a    = ADDR_WIDTH'(dim_k_q);
    assign n_a    = ADDR_WIDTH'(dim_n_q);
    assign ti8    = ADDR_WIDTH'({ti, 3'b000});
    assign tj8    = ADDR_WIDTH'({tj, 3'b000});
    assign tk8    = ADDR_WIDTH'({tk, 3'b000});
    assign r_a    = ADDR_WIDTH'(idx[5:3]);
    assign c_a    = ADDR_WIDTH'(idx[2:0]);
    assign addr_a = base_a_q + ti8 * k_a + tk8;
    assign addr_b = base_b_q + tk8 * n_a + tj8;
    assign addr_c = base_c_q + (ti8 + r_a) * n_a + tj8 + c_a;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        sa_start   = 1'b0;
        write      = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            S_IDLE:    if (start) state_next = cfg_ok ? S_LAUNCH : S_ERR;
            S_ERR: begin
                done       = 1'b1;
                err        = 1'b1;
                state_next = S_IDLE;
            end
            S_LAUNCH: begin
                sa_start   = 1'b1;
                state_next = S_WAIT_SA;
            end
            S_WAIT_SA: if (sa_done) state_next = S_ACCUM;
            S_ACCUM:   state_next = last_tk ? S_WRITE : S_LAUNCH;
            S_WRITE: begin
                write = 1'b1;
                if (write_ready && last_idx)
                    state_next = (last_ti && last_tj) ? S_DONE : S_LAUNCH;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            base_a_q  <= '0;
            base_b_q  <= '0;
            base_c_q  <= '0;
            m_tiles_q <= '0;
            dim_k_q   <= '0;
            dim_n_q   <= '0;
            ti        <= '0;
            tj        <= '0;
            tk        <= '0;
            idx       <= '0;
            acc       <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    base_a_q  <= base_A;
                    base_b_q  <= base_B;
                    base_c_q  <= base_C;
                    m_tiles_q <= dim_M[DIM_WIDTH-1:3];
                    dim_k_q   <= dim_K;
                    dim_n_q   <= dim_N;
                    ti        <= '0;
                    tj        <= '0;
                    tk        <= '0;
                    idx       <= '0;
                end
                S_ACCUM: begin
                    // First K-slice overwrites so stale tiles never leak into the sum
                    for (int e = 0; e < NELEM; e++) begin
                        acc[e*DATA_WIDTH +: DATA_WIDTH] <= (tk == 3'd0) ?
                            sa_out[e*DATA_WIDTH +: DATA_WIDTH] :
                            acc[e*DATA_WIDTH +: DATA_WIDTH] + sa_out[e*DATA_WIDTH +: DATA_WIDTH];
                    end
                    tk <= last_tk ? 3'd0 : tk + 3'd1;
                end
                S_WRITE: if (write_ready) begin
                    idx <= idx + 6'd1;
                    if (last_idx) begin
                        if (last_tj) begin
                            tj <= '0;
                            ti <= last_ti ? 3'd0 : ti + 3'd1;
                        end else begin
                            tj <= tj + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy         = (state != S_IDLE);
    assign sa_base_A    = (state == S_LAUNCH || state == S_WAIT_SA) ? addr_a : '0;
    assign sa_base_B    = (state == S_LAUNCH || state == S_WAIT_SA) ? addr_b : '0;
    assign sa_dim_col_A = dim_k_q;
    assign sa_dim_col_B = dim_n_q;
    assign write_addr   = write ? addr_c : '0;
    assign writedata    = write ? acc[idx*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// tb/tb_matmul_tile_scheduler.sv - directed bench for matmul_tile_scheduler with a driver and memory model
module tb_matmul_tile_scheduler;
    localparam int DW  = 32;
    localparam int AW  = 12;
    localparam int DMW = 7;
    localparam int T   = 8;

    logic clock = 1'b0;
    logic reset, start;
    logic [AW-1:0]  base_A, base_B, base_C;
    logic [DMW-1:0] dim_M, dim_K, dim_N;
    logic busy, done, err, sa_start;
    logic [AW-1:0]  sa_base_A, sa_base_B;
    logic [DMW-1:0] sa_dim_col_A, sa_dim_col_B;
    logic sa_done;
    logic [T*T*DW-1:0] sa_out;
    logic write;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] writedata;
    logic write_ready;

    matmul_tile_scheduler #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIM_WIDTH(DMW), .TILE(T)) dut (
        .clock(clock), .reset(reset), .start(start),
        .base_A(base_A), .base_B(base_B), .base_C(base_C),
        .dim_M(dim_M), .dim_K(dim_K), .dim_N(dim_N),
        .busy(busy), .done(done), .err(err),
        .sa_start(sa_start), .sa_base_A(sa_base_A), .sa_base_B(sa_base_B),
        .sa_dim_col_A(sa_dim_col_A), .sa_dim_col_B(sa_dim_col_B),
        .sa_done(sa_done), .sa_out(sa_out),
        .write(write), .write_addr(write_addr), .writedata(writedata), .write_ready(write_ready)
    );

    always #5 clock = ~clock;

    logic [DW-1:0]  mem [4096];
    logic [AW-1:0]  wr_addr[$];
    logic [DW-1:0]  wr_data[$];
    logic [AW-1:0]  la_a[$], la_b[$];
    logic [DMW-1:0] la_ka[$], la_kb[$];
    logic [AW-1:0]  cur_a, cur_b, hold_addr;
    logic [DMW-1:0] cur_ka, cur_kb;
    logic [DW-1:0]  hold_data, acc_s;
    int checks = 0, errors = 0, cyc = 0, done_count = 0, err_count = 0;
    int done_cyc = 0, last_acc_cyc = 0, hold_viol = 0, stable_viol = 0, sa_delay = 20, cnt = 0;
    bit rdy_toggle = 1'b0, hold_valid = 1'b0;

    // Driver, memory-port and completion monitor; acts on the falling edge
    always @(negedge clock) begin
        cyc++;
        write_ready = rdy_toggle ? ~write_ready : 1'b1;
        if (reset) begin
            cnt = 0;
            hold_valid = 1'b0;
            sa_done = 1'b0;
        end else begin
            if (write && write_ready) begin
                wr_addr.push_back(write_addr);
                wr_data.push_back(writedata);
                last_acc_cyc = cyc;
            end
            if (write) begin
                if (hold_valid && (write_addr !== hold_addr || writedata !== hold_data)) hold_viol++;
                hold_valid = !write_ready;
                hold_addr = write_addr;
                hold_data = writedata;
            end else begin
                hold_valid = 1'b0;
            end
            if (done) begin
                done_count++;
                done_cyc = cyc;
                if (err) err_count++;
            end
            sa_done = 1'b0;
            if (sa_start) begin
                la_a.push_back(sa_base_A);
                la_b.push_back(sa_base_B);
                la_ka.push_back(sa_dim_col_A);
                la_kb.push_back(sa_dim_col_B);
                cur_a = sa_base_A; cur_b = sa_base_B;
                cur_ka = sa_dim_col_A; cur_kb = sa_dim_col_B;
                cnt = sa_delay;
            end else if (cnt > 0) begin
                if (sa_base_A !== cur_a || sa_base_B !== cur_b) stable_viol++;
                cnt--;
                if (cnt == 0) begin
                    for (int r = 0; r < T; r++) begin
                        for (int c = 0; c < T; c++) begin
                            acc_s = '0;
                            for (int kk = 0; kk < T; kk++)
                                acc_s = acc_s + mem[AW'(32'(cur_a) + r * 32'(cur_ka) + kk)] *
                                                mem[AW'(32'(cur_b) + kk * 32'(cur_kb) + c)];
                            sa_out[(r*T+c)*DW +: DW] = acc_s;
                        end
                    end
                    sa_done = 1'b1;
                end
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = '0;
    endtask

    task automatic clear_logs();
        wr_addr.delete(); wr_data.delete();
        la_a.delete(); la_b.delete(); la_ka.delete(); la_kb.delete();
    endtask

    task automatic drive_start(input logic [AW-1:0] ba, bb, bc, input logic [DMW-1:0] m, k, n);
        @(negedge clock); #1;
        base_A = ba; base_B = bb; base_C = bc;
        dim_M = m; dim_K = k; dim_N = n;
        start = 1'b1;
        @(negedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            if (done_count != d0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock); #1;
        end
    endtask

    task automatic run_cmd(input logic [AW-1:0] ba, bb, bc, input logic [DMW-1:0] m, k, n, output bit ok);
        int d0;
        d0 = done_count;
        drive_start(ba, bb, bc, m, k, n);
        wait_done(d0, ok);
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        base_A = '0; base_B = '0; base_C = '0; dim_M = '0; dim_K = '0; dim_N = '0;
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if ({busy, done, err, sa_start, write} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, err, sa_start, write});
        end
        checks++;
        if ({sa_base_A, sa_base_B, write_addr, writedata, sa_dim_col_A, sa_dim_col_B} !== '0) begin
            errors++; $display("FAIL reset_data: got %h expected 0",
                {sa_base_A, sa_base_B, write_addr, writedata, sa_dim_col_A, sa_dim_col_B});
        end
        reset = 1'b0;
    endtask

    task automatic test_identity();
        bit ok;
        int e0;
        clear_mem();
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) begin
            mem[AW'(i*8+j)] = (i == j) ? 32'd1 : 32'd0;
            mem[AW'(12'h100 + i*8 + j)] = DW'(i*8 + j);
        end
        sa_delay = 20; clear_logs(); e0 = err_count;
        run_cmd(12'h000, 12'h100, 12'h300, 7'd8, 7'd8, 7'd8, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ident_timeout: got no done expected done"); end
        checks++;
        if (la_a.size() != 1) begin errors++; $display("FAIL ident_launches: got %0d expected 1", la_a.size()); end
        else begin
            checks++;
            if ({la_a[0], la_b[0], la_ka[0], la_kb[0]} !== {12'h000, 12'h100, 7'd8, 7'd8}) begin
                errors++; $display("FAIL ident_launch_args: got %h %h %0d %0d expected 0 100 8 8",
                    la_a[0], la_b[0], la_ka[0], la_kb[0]);
            end
        end
        checks++;
        if (wr_addr.size() != 64) begin errors++; $display("FAIL ident_nwrites: got %0d expected 64", wr_addr.size()); end
        for (int i = 0; i < 64 && i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] !== AW'(12'h300 + i) || wr_data[i] !== DW'(i)) begin
                errors++; $display("FAIL ident_write[%0d]: got %h=%0d expected %h=%0d",
                    i, wr_addr[i], wr_data[i], AW'(12'h300 + i), i);
            end
        end
        checks++;
        if (done_cyc != last_acc_cyc + 1) begin
            errors++; $display("FAIL ident_done_latency: got %0d expected %0d", done_cyc - last_acc_cyc, 1);
        end
        checks++;
        if (err_count != e0) begin errors++; $display("FAIL ident_err: got %0d expected %0d", err_count, e0); end
    endtask

    task automatic test_multi_tile();
        bit ok;
        logic [AW-1:0] exp_a [4];
        logic [AW-1:0] exp_b [4];
        exp_a = '{12'h000, 12'h000, 12'h040, 12'h040};
        exp_b = '{12'h100, 12'h108, 12'h100, 12'h108};
        clear_mem();
        for (int i = 0; i < 16; i++) for (int k = 0; k < 8; k++) mem[AW'(i*8+k)] = (i % 8 == k) ? 32'd1 : 32'd0;
        for (int k = 0; k < 8; k++) for (int j = 0; j < 16; j++) mem[AW'(12'h100 + k*16 + j)] = DW'(k*16 + j);
        sa_delay = 3; clear_logs();
        run_cmd(12'h000, 12'h100, 12'h200, 7'd16, 7'd8, 7'd16, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL mt_timeout: got no done expected done"); end
        checks++;
        if (la_a.size() != 4) begin errors++; $display("FAIL mt_launches: got %0d expected 4", la_a.size()); end
        for (int t = 0; t < 4 && t < la_a.size(); t++) begin
            checks++;
            if (la_a[t] !== exp_a[t] || la_b[t] !== exp_b[t]) begin
                errors++; $display("FAIL mt_launch[%0d]: got %h %h expected %h %h", t, la_a[t], la_b[t], exp_a[t], exp_b[t]);
            end
        end
        checks++;
        if (wr_addr.size() != 256) begin errors++; $display("FAIL mt_nwrites: got %0d expected 256", wr_addr.size()); end
        else begin
            checks++;
            if (wr_addr[192] !== 12'h288) begin
                errors++; $display("FAIL mt_tile11_first: got %h expected 288", wr_addr[192]);
            end
        end
        for (int w = 0; w < 256 && w < wr_addr.size(); w++) begin
            int ti, tj, r, c;
            ti = w / 128; tj = (w / 64) % 2; r = (w % 64) / 8; c = w % 8;
            checks++;
            if (wr_addr[w] !== AW'(12'h200 + (ti*8 + r)*16 + tj*8 + c) || wr_data[w] !== DW'(r*16 + tj*8 + c)) begin
                errors++; $display("FAIL mt_write[%0d]: got %h=%0d expected %h=%0d", w, wr_addr[w], wr_data[w],
                    AW'(12'h200 + (ti*8 + r)*16 + tj*8 + c), r*16 + tj*8 + c);
            end
        end
    endtask

    task automatic test_k_slices();
        bit ok;
        logic [AW-1:0] exp_a [3];
        logic [AW-1:0] exp_b [3];
        exp_a = '{12'h000, 12'h008, 12'h010};
        exp_b = '{12'h100, 12'h140, 12'h180};
        clear_mem();
        for (int i = 0; i < 192; i++) begin
            mem[AW'(i)] = 32'd1;
            mem[AW'(12'h100 + i)] = 32'd1;
        end
        sa_delay = 5; clear_logs(); stable_viol = 0;
        run_cmd(12'h000, 12'h100, 12'h300, 7'd8, 7'd24, 7'd8, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ks_timeout: got no done expected done"); end
        checks++;
        if (la_a.size() != 3) begin errors++; $display("FAIL ks_launches: got %0d expected 3", la_a.size()); end
        for (int t = 0; t < 3 && t < la_a.size(); t++) begin
            checks++;
            if (la_a[t] !== exp_a[t] || la_b[t] !== exp_b[t] || la_ka[t] !== 7'd24) begin
                errors++; $display("FAIL ks_launch[%0d]: got %h %h %0d expected %h %h 24",
                    t, la_a[t], la_b[t], la_ka[t], exp_a[t], exp_b[t]);
            end
        end
        checks++;
        if (stable_viol != 0) begin errors++; $display("FAIL ks_base_stable: got %0d expected 0", stable_viol); end
        checks++;
        if (wr_addr.size() != 64) begin errors++; $display("FAIL ks_nwrites: got %0d expected 64", wr_addr.size()); end
        for (int i = 0; i < 64 && i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] !== AW'(12'h300 + i) || wr_data[i] !== 32'd24) begin
                errors++; $display("FAIL ks_write[%0d]: got %h=%0d expected %h=24", i, wr_addr[i], wr_data[i], AW'(12'h300 + i));
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_mem();
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) begin
            mem[AW'(i*8+j)] = (i == j) ? 32'd1 : 32'd0;
            mem[AW'(12'h100 + i*8 + j)] = DW'(1000 + i*8 + j);
        end
        sa_delay = 2; clear_logs(); hold_viol = 0; rdy_toggle = 1'b1;
        run_cmd(12'h000, 12'h100, 12'hFF8, 7'd8, 7'd8, 7'd8, ok);
        rdy_toggle = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_timeout: got no done expected done"); end
        checks++;
        if (hold_viol != 0) begin errors++; $display("FAIL bp_hold: got %0d expected 0", hold_viol); end
        checks++;
        if (wr_addr.size() != 64) begin errors++; $display("FAIL bp_nwrites: got %0d expected 64", wr_addr.size()); end
        for (int i = 0; i < 64 && i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] !== AW'(12'hFF8 + i) || wr_data[i] !== DW'(1000 + i)) begin
                errors++; $display("FAIL bp_write[%0d]: got %h=%0d expected %h=%0d", i, wr_addr[i], wr_data[i], AW'(12'hFF8 + i), 1000 + i);
            end
        end
    endtask

    task automatic test_invalid_dims();
        logic [DMW-1:0] tm [3];
        logic [DMW-1:0] tk [3];
        logic [DMW-1:0] tn [3];
        tm = '{7'd8, 7'd0, 7'd8};
        tk = '{7'd12, 7'd8, 7'd8};
        tn = '{7'd8, 7'd8, 7'd72};
        for (int v = 0; v < 3; v++) begin
            clear_logs();
            drive_start(12'h000, 12'h100, 12'h300, tm[v], tk[v], tn[v]);
            checks++;
            if ({busy, done, err} !== 3'b111) begin
                errors++; $display("FAIL inv%0d_err_pulse: got %b expected 111", v, {busy, done, err});
            end
            @(negedge clock); #1;
            checks++;
            if ({busy, done, err} !== 3'b000) begin
                errors++; $display("FAIL inv%0d_idle: got %b expected 000", v, {busy, done, err});
            end
            checks++;
            if (la_a.size() != 0 || wr_addr.size() != 0) begin
                errors++; $display("FAIL inv%0d_activity: got %0d launches %0d writes expected 0 0", v, la_a.size(), wr_addr.size());
            end
        end
    endtask

    task automatic test_max_dims();
        bit ok;
        int nbad;
        clear_mem();
        for (int i = 0; i < 64; i++) for (int k = 0; k < 8; k++) mem[AW'(i*8+k)] = (i % 8 == k) ? 32'd1 : 32'd0;
        for (int k = 0; k < 8; k++) for (int j = 0; j < 64; j++) mem[AW'(12'h200 + k*64 + j)] = DW'(k*64 + j);
        sa_delay = 2; clear_logs();
        run_cmd(12'h000, 12'h200, 12'h400, 7'd64, 7'd8, 7'd64, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL max_timeout: got no done expected done"); end
        checks++;
        if (la_a.size() != 64) begin errors++; $display("FAIL max_launches: got %0d expected 64", la_a.size()); end
        for (int t = 0; t < 64 && t < la_a.size(); t++) begin
            checks++;
            if (la_a[t] !== AW'((t / 8) * 64) || la_b[t] !== AW'(12'h200 + (t % 8) * 8)) begin
                errors++; $display("FAIL max_launch[%0d]: got %h %h expected %h %h", t, la_a[t], la_b[t],
                    AW'((t / 8) * 64), AW'(12'h200 + (t % 8) * 8));
            end
        end
        checks++;
        if (wr_addr.size() != 4096) begin errors++; $display("FAIL max_nwrites: got %0d expected 4096", wr_addr.size()); end
        nbad = 0;
        for (int w = 0; w < 4096 && w < wr_addr.size(); w++) begin
            int ti, tj, r, c;
            ti = w / 512; tj = (w / 64) % 8; r = (w % 64) / 8; c = w % 8;
            checks++;
            if (wr_addr[w] !== AW'(12'h400 + (ti*8 + r)*64 + tj*8 + c) || wr_data[w] !== DW'(r*64 + tj*8 + c)) begin
                errors++; nbad++;
                if (nbad <= 8) $display("FAIL max_write[%0d]: got %h=%0d expected %h=%0d", w, wr_addr[w], wr_data[w],
                    AW'(12'h400 + (ti*8 + r)*64 + tj*8 + c), r*64 + tj*8 + c);
            end
        end
    endtask

    task automatic test_reset_mid_and_busy_start();
        bit ok;
        int d0;
        clear_mem();
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) begin
            mem[AW'(i*8+j)] = (i == j) ? 32'd1 : 32'd0;
            mem[AW'(12'h100 + i*8 + j)] = DW'(500 + i*8 + j);
        end
        sa_delay = 2; clear_logs(); d0 = done_count;
        drive_start(12'h000, 12'h100, 12'h300, 7'd8, 7'd8, 7'd8);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (wr_addr.size() >= 30) begin ok = 1'b1; break; end
            @(negedge clock); #1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_reach_idx30: got %0d writes expected 30", wr_addr.size()); end
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock); #1;
        checks++;
        if ({busy, done, err, sa_start, write} !== 5'b0 || {write_addr, writedata, sa_base_A, sa_base_B} !== '0) begin
            errors++; $display("FAIL rst_outputs: got %b %h expected 00000 0", {busy, done, err, sa_start, write},
                {write_addr, writedata, sa_base_A, sa_base_B});
        end
        reset = 1'b0;
        repeat (5) @(negedge clock);
        #1;
        checks++;
        if (wr_addr.size() != 30 || done_count != d0) begin
            errors++; $display("FAIL rst_abort: got %0d writes %0d dones expected 30 0", wr_addr.size(), done_count - d0);
        end
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) mem[AW'(12'h100 + i*8 + j)] = DW'(700 + i*8 + j);
        clear_logs(); d0 = done_count;
        drive_start(12'h000, 12'h100, 12'h500, 7'd8, 7'd8, 7'd8);
        repeat (2) @(negedge clock);
        drive_start(12'h040, 12'h040, 12'h000, 7'd16, 7'd16, 7'd16);
        wait_done(d0, ok);
        repeat (4) @(negedge clock);
        #1;
        checks++;
        if (!ok) begin errors++; $display("FAIL rst_new_timeout: got no done expected done"); end
        checks++;
        if (done_count != d0 + 1 || busy !== 1'b0 || la_a.size() != 1) begin
            errors++; $display("FAIL rst_busy_start_ignored: got %0d dones busy=%b %0d launches expected 1 0 1",
                done_count - d0, busy, la_a.size());
        end
        checks++;
        if (wr_addr.size() != 64) begin errors++; $display("FAIL rst_new_nwrites: got %0d expected 64", wr_addr.size()); end
        for (int i = 0; i < 64 && i < wr_addr.size(); i++) begin
            checks++;
            if (wr_addr[i] !== AW'(12'h500 + i) || wr_data[i] !== DW'(700 + i)) begin
                errors++; $display("FAIL rst_new_write[%0d]: got %h=%0d expected %h=%0d", i, wr_addr[i], wr_data[i], AW'(12'h500 + i), 700 + i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_multi_tile();
        test_k_slices();
        test_backpressure();
        test_invalid_dims();
        test_max_dims();
        test_reset_mid_and_busy_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
